force_spike_sequencer: RTL and testbench

- Upstream stimulus stage for the tiny SNN network top.
- Drives its force-spike inputs (force_spike_block_select, force_spike_neuron_select, force_spike_en) from a queued schedule of injection commands.
- Each command is (block, neuron, delay). After start, commands are replayed in FIFO order: wait `delay` cycles, then pulse force_spike_en for one cycle with the command's selects.

---
 rtl/force_spike_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_force_spike_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/force_spike_sequencer.sv
// force_spike_sequencer: replays a queue of (block, neuron, delay) commands
// as single-cycle force-spike pulses towards the SNN network top.
// The FIFO flushes on abort. The pulse, its selects, done and busy are all registered.
module force_spike_sequencer #(
    parameter int T     = 4,
    parameter int N     = 16,
    parameter int DEPTH = 8,
    parameter int DW    = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [$clog2(T)-1:0]         cmd_block,
    input  logic [$clog2(N)-1:0]         cmd_neuron,
    input  logic [DW-1:0]                cmd_delay,
    input  logic                         start,
    input  logic                         abort,
    output logic [$clog2(T)-1:0]         force_spike_block_select,
    output logic [$clog2(N)-1:0]         force_spike_neuron_select,
    output logic                         force_spike_en,
    output logic                         busy,
    output logic                         done,
    output logic [15:0]                  fired_count,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
    output logic                         cmd_err
);

    localparam int BW = $clog2(T);
    localparam int NW = $clog2(N);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int EW = BW + NW + DW;

    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
    localparam logic [BW:0]   T_LIM      = (BW + 1)'(T);
    localparam logic [NW:0]   N_LIM      = (NW + 1)'(N);

    typedef enum logic [1:0] {IDLE, WAIT, FIRE, DONE} state_t;

    state_t state, state_n;

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [EW-1:0] head;
    logic [DW-1:0] head_delay;
    logic [NW-1:0] head_neuron;
    logic [BW-1:0] head_block;

    logic          full, in_range, push_hs, do_push, bad_push;
    logic          pop, fire, start_run;

    logic [DW-1:0] cnt;
    logic [BW-1:0] cur_block;
    logic [NW-1:0] cur_neuron;

    assign full      = (fifo_level == FULL_LEVEL);
    assign cmd_ready = !full;
    assign in_range  = ({1'b0, cmd_block} < T_LIM) && ({1'b0, cmd_neuron} < N_LIM);
    assign push_hs   = cmd_valid && !full && !abort;
    assign do_push   = push_hs && in_range;
    assign bad_push  = push_hs && !in_range;

    assign head        = mem[rd_ptr];
    assign head_delay  = head[DW-1:0];
    assign head_neuron = head[DW +: NW];
    assign head_block  = head[DW+NW +: BW];

    // Command storage; contents need no reset because pointers define validity
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= {cmd_block, cmd_neuron, cmd_delay};
        end
    end

    // FIFO pointers and occupancy; abort flushes everything in one cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else if (abort) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, pop})
                2'b10:   fifo_level <= fifo_level + LW'(1);
                2'b01:   fifo_level <= fifo_level - LW'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Sequencer state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    // Next-state and pop/fire decisions; abort forces IDLE and suppresses all actions
    always_comb begin
        state_n   = state;
        pop       = 1'b0;
        fire      = 1'b0;
        start_run = 1'b0;
        if (abort) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        start_run = 1'b1;
                        if (fifo_level != '0) begin
                            pop     = 1'b1;
                            state_n = WAIT;
                        end else begin
                            state_n = DONE;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) state_n = FIRE;
                end
                FIRE: begin
                    fire = 1'b1;
                    if (fifo_level != '0) begin
                        pop     = 1'b1;
                        state_n = WAIT;
                    end else begin
                        state_n = DONE;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // Delay counter, current command, registered outputs and run statistics
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt                       <= '0;
            cur_block                 <= '0;
            cur_neuron                <= '0;
            force_spike_block_select  <= '0;
            force_spike_neuron_select <= '0;
            force_spike_en            <= 1'b0;
            done                      <= 1'b0;
            busy                      <= 1'b0;
            fired_count               <= '0;
            cmd_err                   <= 1'b0;
        end else begin
            if (pop) begin
                cnt        <= head_delay;
                cur_block  <= head_block;
                cur_neuron <= head_neuron;
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - DW'(1);
            end
            if (fire) begin
                force_spike_block_select  <= cur_block;
                force_spike_neuron_select <= cur_neuron;
            end
            force_spike_en <= fire;
            done           <= (state == DONE) && !abort;
            busy           <= (state != IDLE) && !abort;
            if (start_run) begin
                fired_count <= '0;
            end else if (fire && fired_count != 16'hFFFF) begin
                fired_count <= fired_count + 16'd1;
            end
            if (bad_push) begin
                cmd_err <= 1'b1;
            end else if (start_run) begin
                cmd_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_force_spike_sequencer.sv
// Directed testbench for force_spike_sequencer (T=3 so out-of-range blocks exist).
module tb_force_spike_sequencer;

    localparam int T     = 3;
    localparam int N     = 16;
    localparam int DEPTH = 8;
    localparam int DW    = 8;

    logic        clk, reset, cmd_valid, start, abort;
    logic [1:0]  cmd_block;
    logic [3:0]  cmd_neuron;
    logic [7:0]  cmd_delay;
    logic        cmd_ready, force_spike_en, busy, done, cmd_err;
    logic [1:0]  force_spike_block_select;
    logic [3:0]  force_spike_neuron_select;
    logic [15:0] fired_count;
    logic [3:0]  fifo_level;

    int checks   = 0;
    int failures = 0;

    force_spike_sequencer #(.T(T), .N(N), .DEPTH(DEPTH), .DW(DW)) dut (
        .clk                       (clk),
        .reset                     (reset),
        .cmd_valid                 (cmd_valid),
        .cmd_ready                 (cmd_ready),
        .cmd_block                 (cmd_block),
        .cmd_neuron                (cmd_neuron),
        .cmd_delay                 (cmd_delay),
        .start                     (start),
        .abort                     (abort),
        .force_spike_block_select  (force_spike_block_select),
        .force_spike_neuron_select (force_spike_neuron_select),
        .force_spike_en            (force_spike_en),
        .busy                      (busy),
        .done                      (done),
        .fired_count               (fired_count),
        .fifo_level                (fifo_level),
        .cmd_err                   (cmd_err)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [1:0] b, input logic [3:0] n, input logic [7:0] d);
        cmd_valid  = 1'b1;
        cmd_block  = b;
        cmd_neuron = n;
        cmd_delay  = d;
        tick();
        cmd_valid  = 1'b0;
    endtask

    // Leaves the bench just after the edge that samples start (cycle index 0)
    task automatic pulse_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        checks++; if (force_spike_en !== 1'b0) begin failures++; $display("[TB] FAIL reset_en got=%0b exp=0", force_spike_en); end
        checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%0b exp=0", done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready got=%0b exp=1", cmd_ready); end
        checks++; if (fifo_level !== 4'd0) begin failures++; $display("[TB] FAIL reset_level got=%0d exp=0", fifo_level); end
        checks++; if (fired_count !== 16'd0) begin failures++; $display("[TB] FAIL reset_fired got=%0d exp=0", fired_count); end
        checks++; if (cmd_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_err got=%0b exp=0", cmd_err); end
        checks++; if ({force_spike_block_select, force_spike_neuron_select} !== 6'd0) begin failures++; $display("[TB] FAIL reset_sel got=%0h exp=0", {force_spike_block_select, force_spike_neuron_select}); end
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single;
        push_cmd(2'd1, 4'd5, 8'd0);
        checks++; if (fifo_level !== 4'd1) begin failures++; $display("[TB] FAIL single_level got=%0d exp=1", fifo_level); end
        pulse_start();
        checks++; if (force_spike_en !== 1'b0) begin failures++; $display("[TB] FAIL single_en_c0 got=%0b exp=0", force_spike_en); end
        tick();
        checks++; if (force_spike_en !== 1'b0) begin failures++; $display("[TB] FAIL single_en_c1 got=%0b exp=0", force_spike_en); end
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL single_busy_c1 got=%0b exp=1", busy); end
        tick();
        checks++; if (force_spike_en !== 1'b1) begin failures++; $display("[TB] FAIL single_en_c2 got=%0b exp=1", force_spike_en); end
        checks++; if (force_spike_block_select !== 2'd1) begin failures++; $display("[TB] FAIL single_block got=%0d exp=1", force_spike_block_select); end
        checks++; if (force_spike_neuron_select !== 4'd5) begin failures++; $display("[TB] FAIL single_neuron got=%0d exp=5", force_spike_neuron_select); end
        checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL single_done_c2 got=%0b exp=0", done); end
        tick();
        checks++; if (force_spike_en !== 1'b0) begin failures++; $display("[TB] FAIL single_en_c3 got=%0b exp=0", force_spike_en); end
        checks++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL single_done_c3 got=%0b exp=1", done); end
        checks++; if (fired_count !== 16'd1) begin failures++; $display("[TB] FAIL single_fired got=%0d exp=1", fired_count); end
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL single_busy_c3 got=%0b exp=1", busy); end
        tick();
        checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL single_done_c4 got=%0b exp=0", done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL single_busy_c4 got=%0b exp=0", busy); end
    endtask

    task automatic test_three;
        logic exp_en, exp_done;
        push_cmd(2'd0, 4'd1, 8'd0);
        push_cmd(2'd2, 4'd2, 8'd3);
        push_cmd(2'd1, 4'd3, 8'd0);
        pulse_start();
        for (int i = 0; i <= 12; i++) begin
            exp_en   = (i == 2) || (i == 7) || (i == 9);
            exp_done = (i == 10);
            checks++; if (force_spike_en !== exp_en) begin failures++; $display("[TB] FAIL three_en cycle=%0d got=%0b exp=%0b", i, force_spike_en, exp_en); end
            checks++; if (done !== exp_done) begin failures++; $display("[TB] FAIL three_done cycle=%0d got=%0b exp=%0b", i, done, exp_done); end
            if (i == 7) begin
                checks++; if ({force_spike_block_select, force_spike_neuron_select} !== {2'd2, 4'd2}) begin failures++; $display("[TB] FAIL three_sel got=%0d/%0d exp=2/2", force_spike_block_select, force_spike_neuron_select); end
            end
            tick();
        end
        checks++; if (fired_count !== 16'd3) begin failures++; $display("[TB] FAIL three_fired got=%0d exp=3", fired_count); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL three_busy got=%0b exp=0", busy); end
    endtask

    task automatic test_full;
        logic exp_en;
        int   p;
        for (int i = 0; i < 8; i++) push_cmd(2'(i % 3), 4'(i), 8'd0);
        checks++; if (fifo_level !== 4'd8) begin failures++; $display("[TB] FAIL full_level got=%0d exp=8", fifo_level); end
        checks++; if (cmd_ready !== 1'b0) begin failures++; $display("[TB] FAIL full_ready got=%0b exp=0", cmd_ready); end
        push_cmd(2'd0, 4'd15, 8'd0);
        checks++; if (fifo_level !== 4'd8) begin failures++; $display("[TB] FAIL full_ninth got=%0d exp=8", fifo_level); end
        pulse_start();
        for (int i = 0; i <= 20; i++) begin
            exp_en = (i >= 2) && (i <= 16) && (i % 2 == 0);
            checks++; if (force_spike_en !== exp_en) begin failures++; $display("[TB] FAIL full_en cycle=%0d got=%0b exp=%0b", i, force_spike_en, exp_en); end
            checks++; if (done !== (i == 17)) begin failures++; $display("[TB] FAIL full_done cycle=%0d got=%0b", i, done); end
            if (exp_en) begin
                p = (i - 2) / 2;
                checks++; if (force_spike_block_select !== 2'(p % 3) || force_spike_neuron_select !== 4'(p)) begin failures++; $display("[TB] FAIL full_sel pulse=%0d got=%0d/%0d exp=%0d/%0d", p, force_spike_block_select, force_spike_neuron_select, p % 3, p); end
            end
            tick();
        end
        checks++; if (fifo_level !== 4'd0) begin failures++; $display("[TB] FAIL full_level_end got=%0d exp=0", fifo_level); end
        checks++; if (fired_count !== 16'd8) begin failures++; $display("[TB] FAIL full_fired got=%0d exp=8", fired_count); end
    endtask

    task automatic test_empty_and_err;
        pulse_start();
        checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL empty_done_c0 got=%0b exp=0", done); end
        tick();
        checks++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL empty_done_c1 got=%0b exp=1", done); end
        checks++; if (force_spike_en !== 1'b0) begin failures++; $display("[TB] FAIL empty_en got=%0b exp=0", force_spike_en); end
        checks++; if (fired_count !== 16'd0) begin failures++; $display("[TB] FAIL empty_fired got=%0d exp=0", fired_count); end
        tick();
        checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL empty_done_c2 got=%0b exp=0", done); end
        push_cmd(2'd3, 4'd0, 8'd0);
        checks++; if (cmd_err !== 1'b1) begin failures++; $display("[TB] FAIL err_set got=%0b exp=1", cmd_err); end
        checks++; if (fifo_level !== 4'd0) begin failures++; $display("[TB] FAIL err_level got=%0d exp=0", fifo_level); end
        tick();
        checks++; if (cmd_err !== 1'b1) begin failures++; $display("[TB] FAIL err_sticky got=%0b exp=1", cmd_err); end
        pulse_start();
        checks++; if (cmd_err !== 1'b0) begin failures++; $display("[TB] FAIL err_clear got=%0b exp=0", cmd_err); end
        tick();
        tick();
    endtask

    task automatic test_abort;
        push_cmd(2'd2, 4'd9, 8'd200);
        pulse_start();
        repeat (5) tick();
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL abort_busy_pre got=%0b exp=1", busy); end
        abort      = 1'b1;
        cmd_valid  = 1'b1;
        cmd_block  = 2'd0;
        cmd_neuron = 4'd1;
        cmd_delay  = 8'd0;
        tick();
        abort     = 1'b0;
        cmd_valid = 1'b0;
        checks++; if (fifo_level !== 4'd0) begin failures++; $display("[TB] FAIL abort_level got=%0d exp=0", fifo_level); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL abort_busy got=%0b exp=0", busy); end
        checks++; if ({force_spike_block_select, force_spike_neuron_select} !== {2'd1, 4'd7}) begin failures++; $display("[TB] FAIL abort_sel_hold got=%0d/%0d exp=1/7", force_spike_block_select, force_spike_neuron_select); end
        for (int i = 0; i < 10; i++) begin
            checks++; if (force_spike_en !== 1'b0 || done !== 1'b0) begin failures++; $display("[TB] FAIL abort_quiet cycle=%0d en=%0b done=%0b exp=0/0", i, force_spike_en, done); end
            tick();
        end
        pulse_start();
        tick();
        checks++; if (done !== 1'b1 || force_spike_en !== 1'b0) begin failures++; $display("[TB] FAIL abort_restart done=%0b en=%0b exp=1/0", done, force_spike_en); end
        tick();
        tick();
    endtask

    task automatic test_reset_mid;
        push_cmd(2'd2, 4'd3, 8'd0);
        push_cmd(2'd1, 4'd1, 8'd5);
        push_cmd(2'd0, 4'd2, 8'd5);
        pulse_start();
        tick();
        tick();
        checks++; if (force_spike_en !== 1'b1) begin failures++; $display("[TB] FAIL mid_en_pre got=%0b exp=1", force_spike_en); end
        #2 reset = 1'b0;
        #1;
        checks++; if (force_spike_en !== 1'b0) begin failures++; $display("[TB] FAIL mid_en got=%0b exp=0", force_spike_en); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("[TB] FAIL mid_busy_done got=%0b/%0b exp=0/0", busy, done); end
        checks++; if (fifo_level !== 4'd0 || cmd_ready !== 1'b1) begin failures++; $display("[TB] FAIL mid_fifo level=%0d ready=%0b exp=0/1", fifo_level, cmd_ready); end
        checks++; if (fired_count !== 16'd0) begin failures++; $display("[TB] FAIL mid_fired got=%0d exp=0", fired_count); end
        checks++; if ({force_spike_block_select, force_spike_neuron_select} !== 6'd0) begin failures++; $display("[TB] FAIL mid_sel got=%0h exp=0", {force_spike_block_select, force_spike_neuron_select}); end
        tick();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (force_spike_en !== 1'b0 || done !== 1'b0 || fifo_level !== 4'd0) begin failures++; $display("[TB] FAIL mid_after cycle=%0d en=%0b done=%0b level=%0d exp=0/0/0", i, force_spike_en, done, fifo_level); end
        end
    endtask

    // Run every scenario in order and report
    initial begin
        reset      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_block  = '0;
        cmd_neuron = '0;
        cmd_delay  = '0;
        start      = 1'b0;
        abort      = 1'b0;
        test_reset();
        test_single();
        test_three();
        test_full();
        test_empty_and_err();
        test_abort();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
